// File: rtl/link_sched_pkg.sv
// Shared types and helpers for the link token scheduler: link word layout,
// scheduler states and a saturating counter step.
package link_sched_pkg;

  localparam int LINK_W = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND     = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  typedef struct packed {
    logic              wen;
    logic [LINK_W-1:0] token;
    logic [LINK_W-1:0] clk_cnt;
    logic [LINK_W-1:0] id;
  } link_word_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/link_rr_arbiter.sv
// Combinational round-robin pick: first requester set after last_i,
// wrapping modulo N_REQ.
module link_rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic             valid_o,
  output logic [IW-1:0]    index_o,
  output logic [N_REQ-1:0] grant_o
);

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  logic [IW-1:0] cand_s;
  logic          hit_s;

  // Scan candidates in priority order starting just after the last winner.
  always_comb begin
    valid_o = 1'b0;
    index_o = '0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand_s  = IW'((int'(last_i) + i) % N_REQ);
      hit_s   = !valid_o && req_i[cand_s];
      index_o = hit_s ? cand_s : index_o;
      valid_o = valid_o | hit_s;
    end
    grant_o = valid_o ? (ONE_HOT0 << index_o) : '0;
  end

endmodule

// File: rtl/link_token_scheduler.sv
// Round-robin scheduler sharing one link down channel, with echo-acknowledge
// and timeout retry. Optional counters enabled by LINK_TOKEN_SCHED_STATS_EN.
module link_token_scheduler
  import link_sched_pkg::*;
#(
  parameter int                N_REQ       = 4,
  parameter logic [LINK_W-1:0] ID          = 32'd0,
  parameter int                ACK_TIMEOUT = 16,
  parameter int                MAX_RETRY   = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [N_REQ-1:0]        i_req,
  input  logic [N_REQ*LINK_W-1:0] i_token,
  output logic [N_REQ-1:0]        o_grant,
  output logic [N_REQ-1:0]        o_done,
  output logic [N_REQ-1:0]        o_err,
  output logic                    o_busy,
  output logic                    o_wen_down,
  output logic [LINK_W-1:0]       o_token_down,
  output logic [LINK_W-1:0]       o_clk_cnt_down,
  output logic [LINK_W-1:0]       o_id_down,
  input  logic                    i_wen_down,
  input  logic [LINK_W-1:0]       i_token_down,
  input  logic [LINK_W-1:0]       i_clk_cnt_down,
  input  logic [LINK_W-1:0]       i_id_down
`ifdef LINK_TOKEN_SCHED_STATS_EN
  ,
  output logic [15:0]             o_stat_retry,
  output logic [15:0]             o_stat_stray
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int TW = $clog2(ACK_TIMEOUT);
  localparam int RW = $clog2(MAX_RETRY + 2);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [IW-1:0]     last_q, last_d, idx_q, idx_d;
  logic [LINK_W-1:0] tok_q, tok_d, cnt_q;
  logic [RW-1:0]     retry_q, retry_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [N_REQ-1:0]  grant_q, grant_d, done_q, done_d, err_q, err_d;
  link_word_t        link_q, link_d;

  logic              arb_valid_s;
  logic [IW-1:0]     arb_idx_s;
  logic [N_REQ-1:0]  arb_grant_s, onehot_s;
  logic              ack_s, timeout_s;
  logic [LINK_W-1:0] tok_slice_s [N_REQ];
  logic              unused_s;

  for (genvar g = 0; g < N_REQ; g++) begin : g_slice
    assign tok_slice_s[g] = i_token[g*LINK_W +: LINK_W];
  end

  link_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req_i   (i_req),
    .last_i  (last_q),
    .valid_o (arb_valid_s),
    .index_o (arb_idx_s),
    .grant_o (arb_grant_s)
  );

  // The echo stamp is informational only.
  assign unused_s  = ^i_clk_cnt_down;
  assign onehot_s  = ONE_HOT0 << idx_q;
  assign timeout_s = (timer_q == TW'(ACK_TIMEOUT - 1));
  // Echoes count only once the send strobe has left, i.e. from the cycle after it.
  assign ack_s     = (state_q == WAIT_ACK) && !link_q.wen && i_wen_down &&
                     (i_id_down == ID) && (i_token_down == tok_q);

  // Next-state and registered-output decode.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    idx_d    = idx_q;
    tok_d    = tok_q;
    retry_d  = retry_q;
    timer_d  = timer_q;
    grant_d  = '0;
    done_d   = '0;
    err_d    = '0;
    link_d   = link_q;
    link_d.wen = 1'b0;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          grant_d = arb_grant_s;
          idx_d   = arb_idx_s;
          tok_d   = tok_slice_s[arb_idx_s];
          retry_d = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        link_d.wen     = 1'b1;
        link_d.token   = tok_q;
        link_d.clk_cnt = cnt_q + 32'd1;
        link_d.id      = ID;
        timer_d        = '0;
        state_d        = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (ack_s) begin
          done_d  = onehot_s;
          last_d  = idx_q;
          state_d = IDLE;
        end else if (timeout_s) begin
          if (retry_q < RW'(MAX_RETRY)) begin
            retry_d = retry_q + RW'(1);
            state_d = SEND;
          end else begin
            err_d   = onehot_s;
            last_d  = idx_q;
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; cycle counter runs freely and wraps.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= IDLE;
      last_q  <= IW'(N_REQ - 1);
      idx_q   <= '0;
      tok_q   <= '0;
      retry_q <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      link_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      tok_q   <= tok_d;
      retry_q <= retry_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_q + 32'd1;
      grant_q <= grant_d;
      done_q  <= done_d;
      err_q   <= err_d;
      link_q  <= link_d;
    end
  end

  assign o_grant        = grant_q;
  assign o_done         = done_q;
  assign o_err          = err_q;
  assign o_busy         = (state_q != IDLE);
  assign o_wen_down     = link_q.wen;
  assign o_token_down   = link_q.token;
  assign o_clk_cnt_down = link_q.clk_cnt;
  assign o_id_down      = link_q.id;

`ifdef LINK_TOKEN_SCHED_STATS_EN
  logic [15:0] stat_retry_q, stat_stray_q;
  logic        retry_evt_s, stray_evt_s;

  // WAIT_ACK -> SEND only happens on a re-send.
  assign retry_evt_s = (state_q == WAIT_ACK) && (state_d == SEND);
  assign stray_evt_s = i_wen_down && !ack_s;

  // Saturating event counters.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      stat_retry_q <= 16'd0;
      stat_stray_q <= 16'd0;
    end else begin
      stat_retry_q <= retry_evt_s ? sat_inc16(stat_retry_q) : stat_retry_q;
      stat_stray_q <= stray_evt_s ? sat_inc16(stat_stray_q) : stat_stray_q;
    end
  end

  assign o_stat_retry = stat_retry_q;
  assign o_stat_stray = stat_stray_q;
`endif

endmodule

// File: tb/tb_link_token_scheduler.sv
// Self-checking bench for link_token_scheduler: directed vector table,
// hand sequences and randomized transactions against a timing-rule model.
module tb_link_token_scheduler;

  localparam int          N  = 4;
  localparam int          AT = 4;
  localparam int          MR = 2;
  localparam logic [31:0] ID = 32'h0000_00A5;

  logic         clk, rstn;
  logic [3:0]   req;
  logic [31:0]  tok [N];
  logic [127:0] token_bus;
  logic         wen_in;
  logic [31:0]  tok_in, cnt_in, id_in;
  logic [3:0]   grant, done, err;
  logic         busy, wen_out;
  logic [31:0]  tok_out, stamp_out, id_out;
`ifdef LINK_TOKEN_SCHED_STATS_EN
  logic [15:0]  stat_retry, stat_stray;
`endif

  int          checks, errors;
  int          m_last, m_retries, m_strays;
  logic [31:0] m_cnt;

  assign token_bus = {tok[3], tok[2], tok[1], tok[0]};

  link_token_scheduler #(.N_REQ(N), .ID(ID), .ACK_TIMEOUT(AT), .MAX_RETRY(MR)) dut (
    .i_clk          (clk),
    .i_rstn         (rstn),
    .i_req          (req),
    .i_token        (token_bus),
    .o_grant        (grant),
    .o_done         (done),
    .o_err          (err),
    .o_busy         (busy),
    .o_wen_down     (wen_out),
    .o_token_down   (tok_out),
    .o_clk_cnt_down (stamp_out),
    .o_id_down      (id_out),
    .i_wen_down     (wen_in),
    .i_token_down   (tok_in),
    .i_clk_cnt_down (cnt_in),
    .i_id_down      (id_in)
`ifdef LINK_TOKEN_SCHED_STATS_EN
    ,
    .o_stat_retry   (stat_retry),
    .o_stat_stray   (stat_stray)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycles elapsed since the last reset edge.
  always @(posedge clk) begin
    if (!rstn) m_cnt <= 32'd0;
    else       m_cnt <= m_cnt + 32'd1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic drive_idle();
    wen_in = 1'b0;
    tok_in = 32'd0;
    id_in  = 32'd0;
    cnt_in = $urandom;
  endtask

  task automatic chk_quiet(input string name, input bit exp_busy);
    chk(name, {grant, done, err, wen_out, busy}, {12'd0, 1'b0, exp_busy});
  endtask

  task automatic chk_stats(input string name);
`ifdef LINK_TOKEN_SCHED_STATS_EN
    chk({name, "_retry"}, stat_retry, m_retries);
    chk({name, "_stray"}, stat_stray, m_strays);
`else
    chk({name, "_idle"}, busy, 1'b0);
`endif
  endtask

  function automatic int rr_pick(input logic [3:0] rq, input int last);
    int c;
    for (int i = 1; i <= N; i++) begin
      c = (last + i) % N;
      if (rq[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk_all_zero(input string name);
    chk({name, "_ctl"}, {grant, done, err, wen_out, busy}, 14'd0);
    chk({name, "_link"}, {tok_out, stamp_out, id_out}, 96'd0);
  endtask

  // Leaves the bench at the negedge of the first cycle after the reset edge.
  task automatic do_reset();
    step();
    rstn = 1'b0;
    req  = 4'd0;
    drive_idle();
    step();
    rstn      = 1'b1;
    m_last    = N - 1;
    m_retries = 0;
    m_strays  = 0;
    chk_all_zero("reset");
    chk_stats("reset_stats");
  endtask

  // One transaction. Attempt n_fail is echoed at offset d after its send;
  // n_fail > MR means no attempt is echoed. Optional stray strobe at stray_t.
  task automatic serve(input logic [3:0] rq, input int n_fail, input int d,
                       input bit stray_en, input int stray_t, input int kind);
    int          k;
    logic [3:0]  oh;
    logic [31:0] exp_tok, prev_stamp;
    bit          success;
    for (int i = 0; i < N; i++) tok[i] = $urandom;
    if (rq == 4'd0) begin
      req = 4'd0;
      for (int i = 0; i < 3; i++) begin
        step();
        chk_quiet("no_req", 1'b0);
      end
      return;
    end
    k       = rr_pick(rq, m_last);
    oh      = 4'd1 << k;
    exp_tok = tok[k];
    req     = rq;
    step();
    chk("grant", {grant, done, err, wen_out, busy}, {oh, 4'd0, 4'd0, 1'b0, 1'b1});
    req = 4'd0;
    for (int i = 0; i < N; i++) tok[i] = $urandom;
    prev_stamp = 32'd0;
    for (int a = 0; a <= MR; a++) begin
      step();
      chk("send_ctl", {grant, done, err, wen_out, busy}, {12'd0, 1'b1, 1'b1});
      chk("send_link", {tok_out, stamp_out, id_out}, {exp_tok, m_cnt, ID});
      if (a > 0) chk("send_spacing", stamp_out - prev_stamp, AT + 1);
      prev_stamp = stamp_out;
      success = (a == n_fail);
      for (int t = 1; t < AT; t++) begin
        step();
        drive_idle();
        chk_quiet("wait", 1'b1);
        if (success && t == d) begin
          wen_in = 1'b1;
          tok_in = exp_tok;
          id_in  = ID;
          step();
          drive_idle();
          chk("done", {grant, done, err, wen_out, busy}, {4'd0, oh, 4'd0, 2'b00});
          m_last = k;
          return;
        end else if (stray_en && t == stray_t) begin
          wen_in = 1'b1;
          m_strays++;
          tok_in = (kind == 2) ? 32'h0000_DEAD : ((kind == 1) ? exp_tok : exp_tok ^ 32'h0001_0000);
          id_in  = (kind == 1) ? (ID ^ 32'd1) : ID;
        end
      end
      step();
      drive_idle();
      if (a < MR) begin
        chk_quiet("resend_gap", 1'b1);
        m_retries++;
      end else begin
        chk("err", {grant, done, err, wen_out, busy}, {4'd0, 4'd0, oh, 2'b00});
        m_last = k;
        return;
      end
    end
  endtask

  typedef struct {
    logic [3:0]  req;
    logic        ewen;
    logic [31:0] etok;
    logic [3:0]  x_grant, x_done, x_err;
    logic        x_wen, x_busy;
    logic [31:0] x_stamp;
  } vec_t;

  vec_t vec [8];

  initial begin
    int          n_fail, d, stray_t, kind;
    bit          stray_en;
    logic [31:0] t0;
    checks = 0;
    errors = 0;
    rstn   = 1'b0;
    req    = 4'd0;
    for (int i = 0; i < N; i++) tok[i] = $urandom;
    drive_idle();

    // Single request, echo in cycle 5: grant 1, send 2 (stamp 2), done 6.
    vec[0] = '{4'b0001, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'd0};
    vec[1] = '{4'b0000, 1'b0, 32'h0,         4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'd0};
    vec[2] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 32'd2};
    vec[3] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'd0};
    vec[4] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'd0};
    vec[5] = '{4'b0000, 1'b1, 32'hCAFE_0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'd0};
    vec[6] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 32'd0};
    vec[7] = '{4'b0000, 1'b0, 32'h0,         4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'd0};

    do_reset();
    tok[0] = 32'hCAFE_0001;
    for (int r = 0; r < 8; r++) begin
      if (r > 0) step();
      chk($sformatf("vec%0d_ctl", r), {grant, done, err, wen_out, busy},
          {vec[r].x_grant, vec[r].x_done, vec[r].x_err, vec[r].x_wen, vec[r].x_busy});
      if (vec[r].x_wen)
        chk($sformatf("vec%0d_link", r), {tok_out, stamp_out, id_out},
            {32'hCAFE_0001, vec[r].x_stamp, ID});
      req    = vec[r].req;
      wen_in = vec[r].ewen;
      tok_in = vec[r].etok;
      id_in  = ID;
    end
    drive_idle();
    m_last = 0;

    // Fairness: all four requesting, immediate echoes -> 0,1,2,3,0.
    do_reset();
    for (int j = 0; j < 5; j++) serve(4'b1111, 0, 1, 1'b0, 0, 0);

    // Timeout and retry exhaustion: three sends, then error.
    serve(4'b0010, MR + 1, 1, 1'b0, 0, 0);
    chk_stats("after_timeout");

    // Wrong-token stray, then correct echo in the timeout cycle: ack wins.
    serve(4'b1000, 0, AT - 1, 1'b1, 1, 2);
    chk_stats("after_race");

    // Reset in the middle of WAIT_ACK aborts the transfer silently.
    for (int i = 0; i < N; i++) tok[i] = $urandom;
    t0  = tok[0];
    req = 4'b0001;
    step();
    chk("mid_grant", grant, 4'b0001);
    req = 4'd0;
    step();
    chk("mid_send", {wen_out, tok_out}, {1'b1, t0});
    step();
    rstn   = 1'b0;
    wen_in = 1'b1;
    tok_in = t0;
    id_in  = ID;
    step();
    rstn = 1'b1;
    drive_idle();
    m_last    = N - 1;
    m_retries = 0;
    m_strays  = 0;
    chk_all_zero("mid_reset");
    wen_in = 1'b1;
    tok_in = t0;
    id_in  = ID;
    m_strays++;
    for (int i = 0; i < 4; i++) begin
      step();
      drive_idle();
      chk_quiet("post_reset", 1'b0);
    end
    serve(4'b0100, 0, 2, 1'b0, 0, 0);
    chk_stats("after_reset");

    // Randomized transactions.
    for (int j = 0; j < 40; j++) begin
      if ($urandom_range(0, 3) == 0) begin
        wen_in = 1'b1;
        tok_in = $urandom;
        id_in  = ID;
        m_strays++;
        step();
        drive_idle();
        chk_quiet("idle_stray", 1'b0);
      end
      n_fail   = $urandom_range(0, MR + 1);
      d        = $urandom_range(1, AT - 1);
      stray_en = ($urandom_range(0, 1) == 1);
      stray_t  = $urandom_range(1, AT - 1);
      kind     = $urandom_range(0, 1);
      if (n_fail <= MR && stray_t == d) stray_en = 1'b0;
      serve(4'($urandom_range(0, 15)), n_fail, d, stray_en, stray_t, kind);
    end
    chk_stats("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
